// File: rtl/uart_cmd_fifo_if.sv
// Bus between the UART command FIFO and its user: the receiver byte/valid
// pair, the CPU consume request and flush, and the FIFO status/data outputs.
interface uart_cmd_fifo_if #(
    parameter int DEPTH = 8
) ();
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             pop_req;
    logic             clr;
    logic [31:0]      rd_data;
    logic             empty;
    logic             full;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic [3:0]       last_cmd;

    // Side that feeds bytes and consumes entries (receiver + CPU).
    modport master (
        output rx_data, rx_valid, pop_req, clr,
        input  rd_data, empty, full, count, overflow, last_cmd
    );

    // The FIFO itself.
    modport slave (
        input  rx_data, rx_valid, pop_req, clr,
        output rd_data, empty, full, count, overflow, last_cmd
    );
endinterface

// File: rtl/uart_cmd_fifo.sv
// UART command FIFO: turns the receiver's level valid into one push per
// byte, optionally keeps only the U/D/L/R command bytes, queues them and
// hands them to the CPU one entry per rising edge of pop_req. Also keeps a
// one-hot indicator of the last queued command for the LEDs.
module uart_cmd_fifo #(
    parameter int DEPTH  = 8,
    parameter int FILTER = 1
) (
    input  logic           clk,
    input  logic           rst,
    uart_cmd_fifo_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    // Command bytes, slot gi maps to last_cmd bit gi: U, D, L, R.
    localparam logic [31:0] CMD_BYTES = {8'h52, 8'h4C, 8'h44, 8'h55};

    logic             prev_valid_reg;
    logic             prev_pop_reg;
    logic [PTR_W-1:0] wptr_reg, wptr_next;
    logic [PTR_W-1:0] rptr_reg, rptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             overflow_reg, overflow_next;
    logic [3:0]       last_cmd_reg, last_cmd_next;
    logic [7:0]       mem [DEPTH];

    logic [3:0] cmd_hit;
    logic       byte_ok;
    logic       push_evt;
    logic       pop_evt;
    logic       push_ok;
    logic       do_write;
    logic       drop;
    logic       empty_w;
    logic       full_w;

    // One comparator per command byte; the hit vector doubles as the
    // one-hot LED code, so a non-command byte (FILTER=0) decodes to 0000.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cmd
            assign cmd_hit[gi] = (bus.rx_data == CMD_BYTES[gi*8 +: 8]);
        end
    endgenerate

    assign byte_ok  = (FILTER == 0) ? 1'b1 : (|cmd_hit);

    assign empty_w  = (count_reg == '0);
    assign full_w   = (count_reg == FULL_COUNT);

    assign push_evt = bus.rx_valid & ~prev_valid_reg;
    // A consume edge while empty is simply lost; nothing remembers it.
    assign pop_evt  = bus.pop_req & ~prev_pop_reg & ~empty_w;
    assign push_ok  = push_evt & byte_ok;
    // When full, a push is still taken if the head leaves in the same cycle.
    assign do_write = push_ok & (~full_w | pop_evt);
    assign drop     = push_ok & full_w & ~pop_evt;

    // Edge-detect history; deliberately not cleared by clr so a level held
    // across a flush does not look like a fresh event.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_valid_reg <= 1'b0;
            prev_pop_reg   <= 1'b0;
        end else begin
            prev_valid_reg <= bus.rx_valid;
            prev_pop_reg   <= bus.pop_req;
        end
    end

    // Next-state for pointers, occupancy and the sticky/indicator flags.
    always_comb begin
        wptr_next     = wptr_reg;
        rptr_next     = rptr_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;
        last_cmd_next = last_cmd_reg;
        if (bus.clr) begin
            wptr_next     = '0;
            rptr_next     = '0;
            count_next    = '0;
            overflow_next = 1'b0;
            last_cmd_next = 4'b0000;
        end else begin
            if (do_write) begin
                wptr_next     = wptr_reg + PTR_W'(1);
                last_cmd_next = cmd_hit;
            end
            if (pop_evt) begin
                rptr_next = rptr_reg + PTR_W'(1);
            end
            if (drop) begin
                overflow_next = 1'b1;
            end
            case ({do_write, pop_evt})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_reg     <= '0;
            rptr_reg     <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            last_cmd_reg <= 4'b0000;
        end else begin
            wptr_reg     <= wptr_next;
            rptr_reg     <= rptr_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
            last_cmd_reg <= last_cmd_next;
        end
    end

    // Byte storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (!rst && !bus.clr && do_write) begin
            mem[wptr_reg] <= bus.rx_data;
        end
    end

    assign bus.rd_data  = empty_w ? 32'h0 : {24'h0, mem[rptr_reg]};
    assign bus.empty    = empty_w;
    assign bus.full     = full_w;
    assign bus.count    = count_reg;
    assign bus.overflow = overflow_reg;
    assign bus.last_cmd = last_cmd_reg;
endmodule

// File: tb/tb_uart_cmd_fifo.sv
// Directed bench for uart_cmd_fifo (DEPTH=8, FILTER=1): a per-cycle vector
// table plus hand-written sequences for hold, overflow, full push/pop and
// reset corner cases.
module tb_uart_cmd_fifo;
    logic clk = 1'b0;
    logic rst;
    int   vec_count   = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    uart_cmd_fifo_if #(.DEPTH(8)) bus ();

    uart_cmd_fifo #(.DEPTH(8), .FILTER(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [7:0] d;
        logic       v;
        logic       p;
        logic       c;
        int         cnt;
        logic [7:0] rd;
        logic       ov;
        logic [3:0] lc;
    } vec_t;

    vec_t       tbl [19];
    logic [7:0] cmds [4];
    logic [7:0] q [$];

    function automatic vec_t mk(logic [7:0] d, logic v, logic p, logic c,
                                int cnt, logic [7:0] rd, logic ov, logic [3:0] lc);
        vec_t r;
        r.d = d; r.v = v; r.p = p; r.c = c;
        r.cnt = cnt; r.rd = rd; r.ov = ov; r.lc = lc;
        return r;
    endfunction

    task automatic drive(logic [7:0] d, logic v, logic p, logic c);
        bus.rx_data  = d;
        bus.rx_valid = v;
        bus.pop_req  = p;
        bus.clr      = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare every observable output against the expected state.
    task automatic chk_state(string tag, int cnt, logic [7:0] rd, logic ov, logic [3:0] lc);
        logic [31:0] rd32;
        rd32 = (cnt == 0) ? 32'h0 : {24'h0, rd};
        chk({tag, ".count"},    32'(bus.count),    32'(cnt));
        chk({tag, ".rd_data"},  bus.rd_data,       rd32);
        chk({tag, ".empty"},    32'(bus.empty),    32'(cnt == 0));
        chk({tag, ".full"},     32'(bus.full),     32'(cnt == 8));
        chk({tag, ".overflow"}, 32'(bus.overflow), 32'(ov));
        chk({tag, ".last_cmd"}, 32'(bus.last_cmd), 32'(lc));
        $display("%s: count=%0d rd_data=%h empty=%b full=%b overflow=%b last_cmd=%b",
                 tag, bus.count, bus.rd_data, bus.empty, bus.full, bus.overflow, bus.last_cmd);
    endtask

    task automatic push_byte(logic [7:0] b);
        drive(b, 1'b1, 1'b0, 1'b0);
        tick();
        drive(b, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic pop_once();
        drive(8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        cmds[0] = 8'h55; cmds[1] = 8'h44; cmds[2] = 8'h4C; cmds[3] = 8'h52;

        //            d     v     p     c     cnt rd     ov    lc
        tbl[0]  = mk(8'h41, 1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0, 4'b0001);
        tbl[1]  = mk(8'h41, 1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 4'b0001);
        tbl[2]  = mk(8'h44, 1'b1, 1'b0, 1'b0, 1, 8'h44, 1'b0, 4'b0010);
        tbl[3]  = mk(8'h44, 1'b0, 1'b0, 1'b0, 1, 8'h44, 1'b0, 4'b0010);
        tbl[4]  = mk(8'h00, 1'b1, 1'b0, 1'b0, 1, 8'h44, 1'b0, 4'b0010);
        tbl[5]  = mk(8'h00, 1'b0, 1'b0, 1'b0, 1, 8'h44, 1'b0, 4'b0010);
        tbl[6]  = mk(8'h52, 1'b1, 1'b0, 1'b0, 2, 8'h44, 1'b0, 4'b1000);
        tbl[7]  = mk(8'h52, 1'b0, 1'b0, 1'b0, 2, 8'h44, 1'b0, 4'b1000);
        tbl[8]  = mk(8'h00, 1'b0, 1'b1, 1'b0, 1, 8'h52, 1'b0, 4'b1000);
        tbl[9]  = mk(8'h00, 1'b0, 1'b0, 1'b0, 1, 8'h52, 1'b0, 4'b1000);
        tbl[10] = mk(8'h4C, 1'b1, 1'b1, 1'b0, 1, 8'h4C, 1'b0, 4'b0100);
        tbl[11] = mk(8'h4C, 1'b0, 1'b0, 1'b0, 1, 8'h4C, 1'b0, 4'b0100);
        tbl[12] = mk(8'h00, 1'b0, 1'b1, 1'b0, 0, 8'h00, 1'b0, 4'b0100);
        tbl[13] = mk(8'h00, 1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 4'b0100);
        tbl[14] = mk(8'h00, 1'b0, 1'b1, 1'b0, 0, 8'h00, 1'b0, 4'b0100);
        tbl[15] = mk(8'h00, 1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 4'b0100);
        tbl[16] = mk(8'h55, 1'b1, 1'b0, 1'b1, 0, 8'h00, 1'b0, 4'b0000);
        tbl[17] = mk(8'h55, 1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0, 4'b0000);
        tbl[18] = mk(8'h55, 1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 4'b0000);

        // Reset state
        rst = 1'b1;
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        chk_state("reset", 0, 8'h00, 1'b0, 4'b0000);

        // rx_valid held 20 cycles -> one push
        drive(8'h55, 1'b1, 1'b0, 1'b0);
        tick();
        chk_state("hold_first", 1, 8'h55, 1'b0, 4'b0001);
        for (int i = 1; i < 20; i++) tick();
        chk_state("hold_20", 1, 8'h55, 1'b0, 4'b0001);
        drive(8'h55, 1'b0, 1'b0, 1'b0);
        tick();
        pop_once();
        chk_state("hold_popped", 0, 8'h00, 1'b0, 4'b0001);

        // Per-cycle table: filtering, pops, simultaneous push/pop, empty pop, clr
        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].d, tbl[i].v, tbl[i].p, tbl[i].c);
            tick();
            chk_state($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].rd, tbl[i].ov, tbl[i].lc);
        end

        // Overflow: 9 accepted bytes into 8 slots, then flush
        for (int i = 0; i < 9; i++) begin
            push_byte(cmds[i % 4]);
            if (i == 7) chk_state("fill8", 8, 8'h55, 1'b0, 4'b1000);
        end
        chk_state("ovf9", 8, 8'h55, 1'b1, 4'b1000);
        drive(8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        chk_state("clr", 0, 8'h00, 1'b0, 4'b0000);

        // Full FIFO: push on the same edge as a pop rise
        q.delete();
        for (int i = 0; i < 8; i++) begin
            push_byte(cmds[i % 4]);
            q.push_back(cmds[i % 4]);
        end
        drive(8'h4C, 1'b1, 1'b1, 1'b0);
        tick();
        void'(q.pop_front());
        q.push_back(8'h4C);
        chk_state("full_pushpop", 8, q[0], 1'b0, 4'b0100);
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("drain%0d.rd_data", k), bus.rd_data, {24'h0, q[0]});
            $display("drain%0d: rd_data=%h", k, bus.rd_data);
            pop_once();
            void'(q.pop_front());
        end
        chk_state("drained", 0, 8'h00, 1'b0, 4'b0100);

        // pop_req held 50 cycles consumes exactly one entry
        push_byte(8'h55);
        push_byte(8'h44);
        push_byte(8'h52);
        drive(8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 50; i++) tick();
        chk_state("pop_hold50", 2, 8'h44, 1'b0, 4'b1000);
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        pop_once();
        pop_once();
        chk_state("pop_two", 0, 8'h00, 1'b0, 4'b1000);
        pop_once();
        chk_state("pop_empty", 0, 8'h00, 1'b0, 4'b1000);

        // Reset mid-operation with rx_valid high
        for (int i = 0; i < 5; i++) push_byte(cmds[i % 4]);
        chk_state("five", 5, 8'h55, 1'b0, 4'b0001);
        drive(8'h55, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_state("rst_mid", 0, 8'h00, 1'b0, 4'b0000);
        tick();
        chk_state("rst_release", 1, 8'h55, 1'b0, 4'b0001);
        tick();
        chk_state("rst_release_hold", 1, 8'h55, 1'b0, 4'b0001);
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end
endmodule
